data_mem: RTL and testbench

Parametrised single-port data memory that replaces the fixed 128×16 word array next to the CPU. It accepts byte-addressed requests through a valid/ready handshake. Writes are byte-lane masked. Reads return after a configurable latency. Misaligned and out-of-range accesses are reported as errors. After reset the block sweeps the array to zero by itself, so no bench or loader has to preload zeros.

---
 rtl/data_mem_pkg.sv | 17 +
 rtl/data_mem_rsp_pipe.sv | 31 +++
 rtl/data_mem.sv | 135 +++++++++++++
 tb/tb_data_mem.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data_mem block.
package data_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int STAT_W     = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/data_mem_rsp_pipe.sv
// Response delay line carrying {valid, err, rdata}; depth sets the read latency.
module data_mem_rsp_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_rdata,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_rdata
);

    localparam int W = DATA_W + 2;

    logic [W-1:0] stage [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= {in_valid, in_err, in_rdata};
            for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign {out_valid, out_err, out_rdata} = stage[RD_LAT-1];

endmodule

// File: rtl/data_mem.sv
// Byte-addressed, byte-masked data memory with self-clearing init sweep.
// Optional saturating request counters under DATA_MEM_STATS_EN.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
`ifdef DATA_MEM_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_rd,
    output logic [STAT_W-1:0]   stat_wr,
    output logic [STAT_W-1:0]   stat_err
`endif
);

    localparam int BPW   = DATA_W / 8;
    localparam int LSB   = $clog2(BPW);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // An out-of-range RD_LAT is clamped to the legal bounds.
    localparam int LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    state_t           state, state_nx;
    logic             armed, armed_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             sweep_we;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            armed <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            armed <= armed_nx;
            idx   <= idx_nx;
        end
    end

    // The first edge after reset release only arms the sweep; the next DEPTH edges clear the words.
    always_comb begin
        state_nx = state;
        armed_nx = armed;
        idx_nx   = idx;
        sweep_we = 1'b0;
        case (state)
            ST_INIT: begin
                if (!armed) begin
                    armed_nx = 1'b1;
                end else begin
                    sweep_we = 1'b1;
                    if (idx == IDX_W'(DEPTH - 1)) state_nx = ST_RUN;
                    else                          idx_nx   = idx + IDX_W'(1);
                end
            end
            ST_RUN:  state_nx = ST_RUN;
            default: state_nx = ST_INIT;
        endcase
    end

    assign req_ready = (state == ST_RUN);
    assign init_done = (state == ST_RUN);

    logic              accept;
    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              misaligned;
    logic              out_of_range;
    logic              err;
    logic [DATA_W-1:0] rd_word;

    assign accept       = req_valid && req_ready;
    assign word_idx     = req_addr >> LSB;
    assign mem_idx      = word_idx[IDX_W-1:0];
    assign misaligned   = (req_addr & ADDR_W'(BPW - 1)) != '0;
    assign out_of_range = 32'(word_idx) >= DEPTH;
    assign err          = misaligned || out_of_range;
    assign rd_word      = mem[mem_idx];

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[idx] <= '0;
        end else if (accept && req_we && !err) begin
            for (int b = 0; b < BPW; b++) begin
                if (req_be[b]) mem[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
            end
        end
    end

    data_mem_rsp_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (LAT)
    ) u_rsp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_err    (accept && err),
        .in_rdata  ((accept && !req_we && !err) ? rd_word : '0),
        .out_valid (rsp_valid),
        .out_err   (rsp_err),
        .out_rdata (rsp_rdata)
    );

`ifdef DATA_MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_err <= '0;
        end else if (accept) begin
            if (err)         stat_err <= sat_inc(stat_err);
            else if (req_we) stat_wr  <= sat_inc(stat_wr);
            else             stat_rd  <= sat_inc(stat_rd);
        end
    end
`endif

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: a default instance and a DEPTH=64 / RD_LAT=3 instance,
// each checked every cycle against an array-based model with an expected-response queue.
module tb_data_mem;

    localparam int DEPTH_A = 128;
    localparam int LAT_A   = 1;
    localparam int DEPTH_B = 64;
    localparam int LAT_B   = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Request/response: accepted on the rising edge where valid && ready; one rsp_valid pulse per request.
    logic        a_valid, a_we, a_ready, a_rsp_valid, a_err, a_done;
    logic [7:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic [1:0]  a_be;
    logic        b_valid, b_we, b_ready, b_rsp_valid, b_err, b_done;
    logic [7:0]  b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic [1:0]  b_be;
`ifdef DATA_MEM_STATS_EN
    logic [15:0] a_stat_rd, a_stat_wr, a_stat_err;
    logic [15:0] b_stat_rd, b_stat_wr, b_stat_err;
    int srd_a, swr_a, serr_a;
`endif

    data_mem #(.DATA_W(16), .DEPTH(DEPTH_A), .ADDR_W(8), .RD_LAT(LAT_A)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rdata), .rsp_err(a_err), .init_done(a_done)
`ifdef DATA_MEM_STATS_EN
        , .stat_rd(a_stat_rd), .stat_wr(a_stat_wr), .stat_err(a_stat_err)
`endif
    );

    data_mem #(.DATA_W(16), .DEPTH(DEPTH_B), .ADDR_W(8), .RD_LAT(LAT_B)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rdata), .rsp_err(b_err), .init_done(b_done)
`ifdef DATA_MEM_STATS_EN
        , .stat_rd(b_stat_rd), .stat_wr(b_stat_wr), .stat_err(b_stat_err)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rel_cnt = 0;
    logic [15:0] ma [DEPTH_A];
    logic [15:0] mb [DEPTH_B];
    logic [48:0] exp_qa [$];
    logic [48:0] exp_qb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_req(input int sel, input logic we, input logic [7:0] addr,
                             input logic [15:0] wd, input logic [1:0] be,
                             output logic err, output logic [15:0] rd);
        int depth = (sel == 0) ? DEPTH_A : DEPTH_B;
        int word = int'(addr) / 2;
        logic [15:0] cur;
        err = (int'(addr) % 2 != 0) || (word >= depth);
        rd = 16'h0;
        if (!err) begin
            cur = (sel == 0) ? ma[word] : mb[word];
            if (we) begin
                for (int b = 0; b < 2; b++) if (be[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
                if (sel == 0) ma[word] = cur;
                else          mb[word] = cur;
            end else begin
                rd = cur;
            end
        end
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic e,
                             input logic [15:0] d, inout logic [48:0] q [$]);
        logic [48:0] h;
        if (q.size() > 0 && int'(q[0][48:17]) == cyc) begin
            h = q.pop_front();
            check({tag, "_rsp_valid"}, 32'(v), 32'(1'b1));
            check({tag, "_rsp_err"},   32'(e), 32'(h[16]));
            check({tag, "_rsp_rdata"}, 32'(d), 32'(h[15:0]));
        end else begin
            check({tag, "_idle_valid"}, 32'(v), 32'(1'b0));
            check({tag, "_idle_err"},   32'(e), 32'(1'b0));
            check({tag, "_idle_rdata"}, 32'(d), 32'(16'h0));
        end
    endtask

    // One clock: update the model at the rising edge, check the DUT at the falling edge.
    task automatic tick();
        logic e;
        logic [15:0] d;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            exp_qa.delete();
            exp_qb.delete();
            rel_cnt = 0;
            for (int i = 0; i < DEPTH_A; i++) ma[i] = 16'h0;
            for (int i = 0; i < DEPTH_B; i++) mb[i] = 16'h0;
`ifdef DATA_MEM_STATS_EN
            srd_a = 0; swr_a = 0; serr_a = 0;
`endif
        end else begin
            if (a_valid && rel_cnt >= DEPTH_A + 1) begin
                model_req(0, a_we, a_addr, a_wdata, a_be, e, d);
                exp_qa.push_back({32'(cyc + LAT_A - 1), e, d});
`ifdef DATA_MEM_STATS_EN
                if (e) serr_a++; else if (a_we) swr_a++; else srd_a++;
`endif
            end
            if (b_valid && rel_cnt >= DEPTH_B + 1) begin
                model_req(1, b_we, b_addr, b_wdata, b_be, e, d);
                exp_qb.push_back({32'(cyc + LAT_B - 1), e, d});
            end
            rel_cnt++;
        end
        @(negedge clk);
        check("a_ready", 32'(a_ready), 32'(rel_cnt >= DEPTH_A + 1));
        check("a_init_done", 32'(a_done), 32'(rel_cnt >= DEPTH_A + 1));
        check("b_ready", 32'(b_ready), 32'(rel_cnt >= DEPTH_B + 1));
        check("b_init_done", 32'(b_done), 32'(rel_cnt >= DEPTH_B + 1));
        check_rsp("a", a_rsp_valid, a_err, a_rdata, exp_qa);
        check_rsp("b", b_rsp_valid, b_err, b_rdata, exp_qb);
    endtask

    task automatic req_a(input logic we, input logic [7:0] addr, input logic [15:0] wd, input logic [1:0] be);
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic req_b(input logic we, input logic [7:0] addr, input logic [15:0] wd, input logic [1:0] be);
        b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
        tick();
        b_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [7:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
    endfunction

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        #2;
        check("reset_rsp_valid", 32'(a_rsp_valid), 32'(1'b0));
        check("reset_rsp_rdata", 32'(a_rdata), 32'(16'h0));
        check("reset_ready", 32'(a_ready), 32'(1'b0));
        idle(2);
        rst_n = 1'b1;
        // Requests during the sweep must be ignored.
        a_valid = 1'b1; a_we = 1'b1; a_addr = 8'h0C; a_wdata = 16'hBEEF; a_be = 2'b11;
        idle(DEPTH_A + 1);
        a_valid = 1'b0;

        req_a(1'b0, 8'h0C, 16'h0, 2'b00);
        req_a(1'b1, 8'h0C, 16'hD122, 2'b11);
        req_a(1'b0, 8'h0C, 16'h0, 2'b00);
        req_a(1'b1, 8'h04, 16'hF10A, 2'b11);
        req_a(1'b1, 8'h04, 16'h00AB, 2'b01);
        req_a(1'b0, 8'h04, 16'h0, 2'b00);
        req_a(1'b1, 8'h04, 16'h5555, 2'b00);
        req_a(1'b0, 8'h04, 16'h0, 2'b00);
        req_a(1'b1, 8'h02, 16'h1234, 2'b11);
        req_a(1'b0, 8'h03, 16'h0, 2'b00);
        req_a(1'b1, 8'h03, 16'hFFFF, 2'b11);
        req_a(1'b0, 8'h02, 16'h0, 2'b00);
        req_a(1'b0, 8'hFE, 16'h0, 2'b00);

        req_b(1'b1, 8'h02, 16'h00C3, 2'b11);
        req_b(1'b0, 8'h80, 16'h0, 2'b00);
        req_b(1'b1, 8'h80, 16'hAAAA, 2'b11);
        req_b(1'b0, 8'h02, 16'h0, 2'b00);
        for (int i = 0; i < 4; i++) req_b(1'b1, 8'(2 * i), 16'(i + 1), 2'b11);
        for (int i = 0; i < 4; i++) req_b(1'b0, 8'(2 * i), 16'h0, 2'b00);
        idle(LAT_B + 1);

        for (int i = 0; i < 400; i++) begin
            a_valid = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
            a_addr = rand_addr(); a_wdata = 16'($urandom); a_be = 2'($urandom_range(0, 3));
            b_valid = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
            b_addr = rand_addr(); b_wdata = 16'($urandom); b_be = 2'($urandom_range(0, 3));
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        idle(LAT_B + 1);
`ifdef DATA_MEM_STATS_EN
        check("a_stat_rd", 32'(a_stat_rd), 32'(srd_a));
        check("a_stat_wr", 32'(a_stat_wr), 32'(swr_a));
        check("a_stat_err", 32'(a_stat_err), 32'(serr_a));
`endif

        // Reset with two reads in flight on the 3-cycle instance.
        req_b(1'b1, 8'h06, 16'h7777, 2'b11);
        req_b(1'b0, 8'h06, 16'h0, 2'b00);
        req_b(1'b0, 8'h06, 16'h0, 2'b00);
        rst_n = 1'b0;
        idle(2);
`ifdef DATA_MEM_STATS_EN
        check("rst_a_stat_rd", 32'(a_stat_rd), 32'(0));
        check("rst_a_stat_wr", 32'(a_stat_wr), 32'(0));
        check("rst_a_stat_err", 32'(a_stat_err), 32'(0));
        check("rst_b_stat_rd", 32'(b_stat_rd), 32'(0));
        check("rst_b_stat_wr", 32'(b_stat_wr), 32'(0));
        check("rst_b_stat_err", 32'(b_stat_err), 32'(0));
`endif
        rst_n = 1'b1;
        idle(DEPTH_A + 1);
        req_a(1'b0, 8'h0C, 16'h0, 2'b00);
        req_a(1'b0, 8'h04, 16'h0, 2'b00);
        req_b(1'b0, 8'h06, 16'h0, 2'b00);
        req_b(1'b0, 8'h00, 16'h0, 2'b00);
        idle(LAT_B + 1);
        check("a_queue_drained", 32'(exp_qa.size()), 32'(0));
        check("b_queue_drained", 32'(exp_qb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
